// File: rtl/demux_stream_pkg.sv
// Shared types and constants for the stream demultiplexer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package demux_stream_pkg;

    // Occupancy of one output register
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_e;

    // Width of the saturating drop counter
    localparam int DROP_W = 8;

endpackage

// File: rtl/demux_stream_onehot_decoder.sv
// Binary index to one-hot mask decoder, zero for out-of-range index or en=0.
// Latency: combinational.
// Backpressure: not applicable.
module onehot_decoder #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [SW-1:0] idx,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    // One extra bit so the index can be compared against every position
    // without truncation, even when N is a power of two.
    localparam int SW1 = SW + 1;

    // Set the bit whose position equals idx; indices >= N match nothing
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && ({1'b0, idx} == SW1'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_stream.sv
// N-channel stream demux: unicast/broadcast into a one-entry register per channel.
// Latency: beat accepted at edge k is visible on out_valid/out_data in cycle k+1.
// Backpressure: in_ready = all targeted channels free; out-of-range unicast is always taken and dropped.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int CH = 8,
    parameter int DW = 8,
    parameter int SW = $clog2(CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        in_data,
    input  logic [SW-1:0]        in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CH*DW-1:0]     out_data,
    output logic [CH-1:0]        out_valid,
    input  logic [CH-1:0]        out_ready,
    output logic                 err_sel,
    output logic [DROP_W-1:0]    drop_cnt
);

    localparam int                SW1     = SW + 1;
    localparam logic [SW:0]       CH_LIM  = SW1'(CH);
    localparam logic [DROP_W-1:0] CNT_MAX = '1;

    logic [CH-1:0] uni_mask;
    logic [CH-1:0] mask;
    logic [CH-1:0] free;
    logic [CH-1:0] load;
    logic          sel_bad;
    logic          accept;
    logic          drop;

    onehot_decoder #(
        .N  (CH),
        .SW (SW)
    ) u_dec (
        .idx    (in_sel),
        .en     (!in_bcast),
        .onehot (uni_mask)
    );

    // Target selection and handshake; in_valid only qualifies accept, never in_ready
    always_comb begin
        mask     = in_bcast ? {CH{1'b1}} : uni_mask;
        sel_bad  = !in_bcast && ({1'b0, in_sel} >= CH_LIM);
        free     = ~out_valid | out_ready;
        in_ready = sel_bad || (&(free | ~mask));
        accept   = in_valid && in_ready;
        drop     = accept && sel_bad;
        load     = mask & {CH{accept}};
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        ch_state_e     state_q;
        ch_state_e     state_d;
        logic [DW-1:0] data_q;

        // Channel occupancy register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        // Fill on load; empty only on drain with no refill in the same cycle
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_EMPTY: if (load[i])                  state_d = ST_FULL;
                ST_FULL:  if (out_ready[i] && !load[i]) state_d = ST_EMPTY;
                default:                                state_d = ST_EMPTY;
            endcase
        end

        // Payload only changes on load, so it holds steady while stalled
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (load[i]) begin
                data_q <= in_data;
            end
        end

        assign out_valid[i]           = (state_q == ST_FULL);
        assign out_data[i*DW +: DW]   = data_q;
    end

    // One err_sel pulse per dropped beat; counter sticks at its maximum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            err_sel <= drop;
            if (drop && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench: directed scenarios on CH=8, drops and random traffic on CH=5.
// Latency: n/a.
// Backpressure: n/a.
module tb_demux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // CH=8 instance
    logic [7:0]  a_data;
    logic [2:0]  a_sel;
    logic        a_bc;
    logic        a_valid;
    logic        a_ready;
    logic [63:0] a_odata;
    logic [7:0]  a_ovalid;
    logic [7:0]  a_ordy;
    logic        a_err;
    logic [7:0]  a_cnt;

    // CH=5 instance
    logic [7:0]  b_data;
    logic [2:0]  b_sel;
    logic        b_bc;
    logic        b_valid;
    logic        b_ready;
    logic [39:0] b_odata;
    logic [4:0]  b_ovalid;
    logic [4:0]  b_ordy;
    logic        b_err;
    logic [7:0]  b_cnt;

    // Reference model of the CH=5 instance: what each consumer is still owed
    logic [7:0] mq [5][$];

    demux_stream #(.CH(8), .DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_bcast(a_bc),
        .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_valid(a_ovalid),
        .out_ready(a_ordy), .err_sel(a_err), .drop_cnt(a_cnt)
    );

    demux_stream #(.CH(5), .DW(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_bcast(b_bc),
        .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_valid(b_ovalid),
        .out_ready(b_ordy), .err_sel(b_err), .drop_cnt(b_cnt)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        a_data = '0; a_sel = '0; a_bc = 1'b0; a_valid = 1'b0; a_ordy = '1;
        b_data = '0; b_sel = '0; b_bc = 1'b0; b_valid = 1'b0; b_ordy = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (a_ovalid !== 8'h00) begin bad++; $display("FAIL reset_valid8 got=%h exp=00", a_ovalid); end
        total++; if (a_odata !== 64'h0) begin bad++; $display("FAIL reset_data8 got=%h exp=0", a_odata); end
        total++; if (a_err !== 1'b0 || a_cnt !== 8'd0) begin bad++; $display("FAIL reset_err8 got=%b/%0d exp=0/0", a_err, a_cnt); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready8 got=%b exp=1", a_ready); end
        total++; if (b_ovalid !== 5'h00 || b_cnt !== 8'd0) begin bad++; $display("FAIL reset_dut5 got=%h/%0d exp=00/0", b_ovalid, b_cnt); end
    endtask

    task automatic test_unicast_stream();
        @(negedge clk);
        a_ordy = '1; a_valid = 1'b1; a_bc = 1'b0; a_sel = 3'd3; a_data = 8'h11;
        @(posedge clk);
        @(negedge clk);
        a_data = 8'h22;
        #1;
        total++; if (a_ovalid !== 8'h08) begin bad++; $display("FAIL uni_valid1 got=%h exp=08", a_ovalid); end
        total++; if (a_odata[31:24] !== 8'h11) begin bad++; $display("FAIL uni_data1 got=%h exp=11", a_odata[31:24]); end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        total++; if (a_ovalid !== 8'h08) begin bad++; $display("FAIL uni_valid2 got=%h exp=08", a_ovalid); end
        total++; if (a_odata[31:24] !== 8'h22) begin bad++; $display("FAIL uni_data2 got=%h exp=22", a_odata[31:24]); end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (a_ovalid !== 8'h00) begin bad++; $display("FAIL uni_drained got=%h exp=00", a_ovalid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        a_ordy = 8'hDF; a_valid = 1'b1; a_bc = 1'b0; a_sel = 3'd5; a_data = 8'hA5;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_empty got=%b exp=1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        a_data = 8'h5A;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", a_ready); end
        total++; if (a_ovalid !== 8'h20 || a_odata[47:40] !== 8'hA5) begin bad++; $display("FAIL bp_held got=%h/%h exp=20/a5", a_ovalid, a_odata[47:40]); end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_novalid got=%b exp=0", a_ready); end
        total++; if (a_odata[47:40] !== 8'hA5) begin bad++; $display("FAIL bp_stable got=%h exp=a5", a_odata[47:40]); end
        a_valid = 1'b1; a_ordy = 8'hFF;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_release got=%b exp=1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        #1;
        total++; if (a_ovalid !== 8'h20 || a_odata[47:40] !== 8'h5A) begin bad++; $display("FAIL bp_reload got=%h/%h exp=20/5a", a_ovalid, a_odata[47:40]); end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (a_ovalid !== 8'h00) begin bad++; $display("FAIL bp_drained got=%h exp=00", a_ovalid); end
    endtask

    task automatic test_broadcast();
        @(negedge clk);
        a_ordy = 8'hFB; a_valid = 1'b1; a_bc = 1'b0; a_sel = 3'd2; a_data = 8'h77;
        @(posedge clk);
        @(negedge clk);
        a_bc = 1'b1; a_sel = 3'd6; a_data = 8'hC3;
        #1;
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL bc_ready_blocked got=%b exp=0", a_ready); end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (a_ovalid !== 8'h04 || a_odata[23:16] !== 8'h77) begin bad++; $display("FAIL bc_no_partial got=%h/%h exp=04/77", a_ovalid, a_odata[23:16]); end
        a_ordy = 8'hFF;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL bc_ready_release got=%b exp=1", a_ready); end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; a_bc = 1'b0;
        #1;
        total++; if (a_ovalid !== 8'hFF) begin bad++; $display("FAIL bc_valid got=%h exp=ff", a_ovalid); end
        total++; if (a_odata !== 64'hC3C3_C3C3_C3C3_C3C3) begin bad++; $display("FAIL bc_data got=%h exp=c3c3c3c3c3c3c3c3", a_odata); end
        @(posedge clk);
    endtask

    task automatic test_drop_burst();
        @(negedge clk);
        b_ordy = '1; b_valid = 1'b1; b_bc = 1'b0; b_sel = 3'd6; b_data = 8'h99;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
            end
            #1;
            total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL drop_ready[%0d] got=%b exp=1", k, b_ready); end
            if (k > 0) begin
                total++; if (b_err !== 1'b1) begin bad++; $display("FAIL drop_err[%0d] got=%b exp=1", k, b_err); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        b_valid = 1'b0;
        #1;
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL drop_err_last got=%b exp=1", b_err); end
        total++; if (b_cnt !== 8'd3) begin bad++; $display("FAIL drop_cnt got=%0d exp=3", b_cnt); end
        total++; if (b_ovalid !== 5'h00) begin bad++; $display("FAIL drop_no_valid got=%h exp=00", b_ovalid); end
        @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL drop_err_clear got=%b exp=0", b_err); end
    endtask

    task automatic test_drop_saturate();
        @(negedge clk);
        b_valid = 1'b1; b_bc = 1'b0; b_sel = 3'd7;
        repeat (260) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (b_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", b_cnt); end
        total++; if (b_err !== 1'b1) begin bad++; $display("FAIL sat_err_pulse got=%b exp=1", b_err); end
        b_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (b_cnt !== 8'd255 || b_err !== 1'b0) begin bad++; $display("FAIL sat_hold got=%0d/%b exp=255/0", b_cnt, b_err); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a_ordy = '0; a_valid = 1'b1; a_bc = 1'b1; a_data = 8'h3C;
        b_ordy = '1; b_valid = 1'b1; b_bc = 1'b0; b_sel = 3'd7;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; a_bc = 1'b0;
        #1;
        total++; if (a_ovalid !== 8'hFF || b_err !== 1'b1) begin bad++; $display("FAIL arst_pre got=%h/%b exp=ff/1", a_ovalid, b_err); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (a_ovalid !== 8'h00) begin bad++; $display("FAIL arst_valid got=%h exp=00", a_ovalid); end
        total++; if (a_odata !== 64'h0) begin bad++; $display("FAIL arst_data got=%h exp=0", a_odata); end
        total++; if (b_err !== 1'b0 || b_cnt !== 8'd0) begin bad++; $display("FAIL arst_err_cnt got=%b/%0d exp=0/0", b_err, b_cnt); end
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a_ordy = '1;
    endtask

    task automatic test_random();
        logic [4:0] exp_v;
        logic [7:0] exp_cnt;
        logic       exp_err;
        logic       exp_r;
        logic       sel_bad;
        logic       acc;
        int         drops;
        drops   = 0;
        exp_err = 1'b0;
        for (int i = 0; i < 5; i++) mq[i].delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            b_valid = ($urandom_range(9) < 7);
            b_bc    = ($urandom_range(7) == 0);
            b_sel   = 3'($urandom_range(7));
            b_data  = 8'($urandom);
            b_ordy  = 5'($urandom);
            #1;
            for (int i = 0; i < 5; i++) exp_v[i] = (mq[i].size() != 0);
            exp_cnt = (drops > 255) ? 8'd255 : 8'(drops);
            total++; if (b_ovalid !== exp_v) begin bad++; $display("FAIL rnd_valid c=%0d got=%h exp=%h", c, b_ovalid, exp_v); end
            for (int i = 0; i < 5; i++) begin
                if (exp_v[i]) begin
                    total++; if (b_odata[8*i +: 8] !== mq[i][0]) begin bad++; $display("FAIL rnd_data c=%0d ch=%0d got=%h exp=%h", c, i, b_odata[8*i +: 8], mq[i][0]); end
                end
            end
            total++; if (b_err !== exp_err) begin bad++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, b_err, exp_err); end
            total++; if (b_cnt !== exp_cnt) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, b_cnt, exp_cnt); end
            sel_bad = !b_bc && (int'(b_sel) >= 5);
            exp_r   = 1'b1;
            if (!sel_bad) begin
                for (int i = 0; i < 5; i++) begin
                    if ((b_bc || int'(b_sel) == i) && exp_v[i] && !b_ordy[i]) exp_r = 1'b0;
                end
            end
            total++; if (b_ready !== exp_r) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, b_ready, exp_r); end
            // What this clock edge does: consumers take heads, then the new beat is delivered
            acc = b_valid && exp_r;
            for (int i = 0; i < 5; i++) begin
                if (exp_v[i] && b_ordy[i]) void'(mq[i].pop_front());
            end
            exp_err = acc && sel_bad;
            if (acc) begin
                if (sel_bad) begin
                    drops++;
                end else begin
                    for (int i = 0; i < 5; i++) begin
                        if (b_bc || int'(b_sel) == i) mq[i].push_back(b_data);
                    end
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        b_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unicast_stream();
        test_backpressure();
        test_broadcast();
        test_drop_burst();
        test_drop_saturate();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_stream.md
# demux_stream

Parametrised N-channel stream demultiplexer with valid/ready handshake and a one-entry output register per channel. It generalises the fixed 3-to-8 decoder/demultiplexer:
- any channel count and data width;
- unicast and broadcast modes;
- back-pressure per channel;
- detection of out-of-range selects, with a drop counter.

It sits between a single producer and CH independent consumers.

## Interface
Parameters:
- CH, 8, number of output channels, 2..64, need not be a power of two
- DW, 8, data width per beat
- SW, $clog2(CH), select width; derived, never overridden

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DW  beat payload
- in_sel  in  SW  target channel index (unicast)
- in_bcast  in  1  1 = deliver beat to all channels, in_sel ignored
- in_valid  in  1  producer has a beat
- in_ready  out  1  beat accepted this cycle when in_valid & in_ready
- out_data  out  CH*DW  channel i payload at [i*DW +: DW]
- out_valid  out  CH  channel i register full
- out_ready  in  CH  consumer i takes beat when out_valid[i] & out_ready[i]
- err_sel  out  1  one-cycle pulse: a beat with in_sel >= CH was consumed
- drop_cnt  out  8  saturating count of dropped (out-of-range) beats

## Operation
- Each channel is a 2-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL stays FULL on drain+load, with new data.
- free[i] = !out_valid[i] | out_ready[i].
- Target mask:
  - in_bcast=1: all ones.
  - otherwise: onehot(in_sel), or all zeros when in_sel >= CH (invalid).
- in_ready:
  - invalid unicast: in_ready = 1; beat is always consumed.
  - otherwise: in_ready = AND of free[i] over all i set in the mask.
  - Broadcast never partially delivers; it waits until every channel is free.
- On accept: every masked channel loads in_data and goes FULL. Unmasked channels only drain.
- On accept of an invalid unicast:
  - no channel loads;
  - err_sel = 1 next cycle;
  - drop_cnt increments, saturating at 255.
- in_ready depends combinationally on out_valid and out_ready only. It never depends on in_valid, in_data or in_sel, with one exception: in_ready may depend on in_sel/in_bcast for mask selection. in_valid must not feed in_ready.
- Reset (asynchronous assert, any time):
  - out_valid = 0, out_data = 0, err_sel = 0, drop_cnt = 0;
  - all channels go EMPTY;
  - held beats are lost.
  - Deassertion is synchronous to clk, i.e. a synchronised release is supplied externally.

## Timing
- Latency: beat accepted at edge k is visible on out_valid/out_data after edge k (cycle k+1).
- Throughput: 1 beat/cycle to one channel when out_ready is held high (simultaneous drain and load).
- Simultaneous load on channel i and out_ready[i]=1 with out_valid[i]=1: old beat is consumed and the new beat is held. No bubble, no loss.
- out_data[i] is stable while out_valid[i]=1 and out_ready[i]=0.
- err_sel is high exactly one cycle per dropped beat. Back-to-back drops keep it high on consecutive cycles.
- drop_cnt at 255 stays 255. err_sel still pulses.

## Structure
- Shared package:
  - channel FSM state enum (ST_EMPTY, ST_FULL);
  - drop counter width constant (DROP_W = 8).
- Sub-module onehot_decoder:
  - parameters N and SW;
  - input idx, input en, output [N-1:0] onehot;
  - output is zero when idx >= N or en = 0;
  - supplies the unicast mask.
- Per-channel register and FSM are instantiated via a generate loop in the top.

## Test plan
- CH=8, DW=8, all out_ready=1: send 0x11 sel 3, 0x22 sel 3 on consecutive cycles -> out_valid[3] high two cycles, data 0x11 then 0x22; other channels stay 0.
- out_ready[5]=0, send 0xA5 sel 5 then 0x5A sel 5 -> first beat held, in_ready=0 for second. Raise out_ready[5] -> 0xA5 drains, 0x5A loads the same edge.
- Broadcast 0xC3 with out_ready[2]=0 and channel 2 FULL -> in_ready=0, no channel loads. Release out_ready[2] -> all 8 channels show 0xC3 next cycle.
- CH=5, send sel 6 three times back-to-back -> in_ready=1 throughout, err_sel high 3 cycles, drop_cnt=3, no out_valid.
- Send 260 invalid beats -> drop_cnt saturates at 255.
- Assert rst_n low mid-stream with channels FULL -> out_valid, out_data, drop_cnt and err_sel go to 0 immediately, without a clock edge.
